// File: rtl/connect_flit_pkg.sv
// Shared flit/credit definitions for the send and receive sides of the
// flit network: default widths, flit field offsets, and packed flit/credit
// types. Blocks built with non-default parameters derive their own widths
// using the same helper functions, so the layouts always agree.
package connect_flit_pkg;

    localparam int NUM_VCS_DEF         = 2;
    localparam int FLIT_DATA_WIDTH_DEF = 40;
    localparam int DEST_BITS_DEF       = 2;
    localparam int BUF_DEPTH_DEF       = 4;

    // A VC field always has at least one bit, even when there is a single VC.
    function automatic int vc_bits(input int nvc);
        return (nvc <= 2) ? 1 : $clog2(nvc);
    endfunction

    function automatic int flit_w(input int nvc, input int dw, input int db);
        return 2 + dw + db + vc_bits(nvc);
    endfunction

    function automatic int credit_w(input int nvc);
        return 1 + vc_bits(nvc);
    endfunction

    localparam int VC_BITS_DEF  = vc_bits(NUM_VCS_DEF);
    localparam int FLIT_W_DEF   = flit_w(NUM_VCS_DEF, FLIT_DATA_WIDTH_DEF, DEST_BITS_DEF);
    localparam int CREDIT_W_DEF = credit_w(NUM_VCS_DEF);

    // Flit layout, MSB first: {valid, tail, dest, vc, data}
    localparam int FLIT_DATA_LSB  = 0;
    localparam int FLIT_VC_LSB    = FLIT_DATA_LSB + FLIT_DATA_WIDTH_DEF;
    localparam int FLIT_DEST_LSB  = FLIT_VC_LSB + VC_BITS_DEF;
    localparam int FLIT_TAIL_BIT  = FLIT_DEST_LSB + DEST_BITS_DEF;
    localparam int FLIT_VALID_BIT = FLIT_TAIL_BIT + 1;

    typedef struct packed {
        logic                           valid;
        logic                           tail;
        logic [DEST_BITS_DEF-1:0]       dest;
        logic [VC_BITS_DEF-1:0]         vc;
        logic [FLIT_DATA_WIDTH_DEF-1:0] data;
    } flit_t;

    typedef struct packed {
        logic                   valid;
        logic [VC_BITS_DEF-1:0] vc;
    } credit_t;

    typedef enum logic {
        SEL_IDLE   = 1'b0,
        SEL_LOCKED = 1'b1
    } sel_state_e;

endpackage

// File: rtl/flit_recv_endpoint_if.sv
// Network-side and user-side signals of the flit receive endpoint.
// master: the environment (network port + user logic); slave: the endpoint.
interface flit_recv_endpoint_if
    import connect_flit_pkg::*;
#(
    parameter int NUM_VCS         = NUM_VCS_DEF,
    parameter int FLIT_DATA_WIDTH = FLIT_DATA_WIDTH_DEF,
    parameter int DEST_BITS       = DEST_BITS_DEF
);
    localparam int VC_BITS  = vc_bits(NUM_VCS);
    localparam int FLIT_W   = flit_w(NUM_VCS, FLIT_DATA_WIDTH, DEST_BITS);
    localparam int CREDIT_W = credit_w(NUM_VCS);

    logic [FLIT_W-1:0]          flit_in;
    logic [CREDIT_W-1:0]        credit_out;
    logic                       credit_out_en;
    logic                       out_valid;
    logic                       out_ready;
    logic [FLIT_DATA_WIDTH-1:0] out_data;
    logic                       out_tail;
    logic [VC_BITS-1:0]         out_vc;

    modport master (
        output flit_in, out_ready,
        input  credit_out, credit_out_en, out_valid, out_data, out_tail, out_vc
    );

    modport slave (
        input  flit_in, out_ready,
        output credit_out, credit_out_en, out_valid, out_data, out_tail, out_vc
    );

endinterface

// File: rtl/flit_vc_fifo.sv
// Single-VC flit buffer: power-of-two depth, wrapping pointers and an
// occupancy counter with DEPTH+1 states. The caller guarantees no write
// when full (unless a read happens the same cycle) and no read when empty.
module flit_vc_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
)(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wptr;
    logic [PTR_W-1:0]            rptr;

    // Storage array; contents are only meaningful where count says so.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    // Pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rptr];
    assign full    = (count == ($clog2(DEPTH+1))'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/flit_recv_endpoint.sv
// Flit receive endpoint: buffers incoming flits per VC, presents one flit at a
// time to the user with packet-atomic round-robin selection across VCs, and
// returns one credit per dequeued flit. Flits hitting a full VC are dropped
// and raise a sticky overflow flag.
// Optional build macro FLIT_RECV_STATS_EN adds stat_flits/stat_pkts counters.
module flit_recv_endpoint
    import connect_flit_pkg::*;
#(
    parameter int NUM_VCS         = NUM_VCS_DEF,
    parameter int FLIT_DATA_WIDTH = FLIT_DATA_WIDTH_DEF,
    parameter int DEST_BITS       = DEST_BITS_DEF,
    parameter int BUF_DEPTH       = BUF_DEPTH_DEF
)(
    input  logic                 clock,
    input  logic                 reset,
    flit_recv_endpoint_if.slave  bus,
    output logic                 error_overflow
`ifdef FLIT_RECV_STATS_EN
    ,
    output logic [31:0]          stat_flits,
    output logic [31:0]          stat_pkts
`endif
);
    localparam int VC_BITS = vc_bits(NUM_VCS);
    localparam int ENTRY_W = 1 + FLIT_DATA_WIDTH;   // {tail, data}
    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic                       valid;
        logic                       tail;
        logic [DEST_BITS-1:0]       dest;
        logic [VC_BITS-1:0]         vc;
        logic [FLIT_DATA_WIDTH-1:0] data;
    } rx_flit_t;

    rx_flit_t fin;
    assign fin = bus.flit_in;

    // Destination was already used by the network for routing.
    logic unused_dest;
    assign unused_dest = ^fin.dest;

    logic [NUM_VCS-1:0]              hit, room, wr_en, rd_en, ovf, full, empty;
    logic [NUM_VCS-1:0][ENTRY_W-1:0] head;
    logic [NUM_VCS-1:0][CNT_W-1:0]   count;

    sel_state_e         state_q, state_d;
    logic [VC_BITS-1:0] lock_vc_q, lock_vc_d;
    logic [VC_BITS-1:0] rr_ptr_q, rr_ptr_d;    // highest-priority VC in IDLE
    logic [VC_BITS-1:0] sel, cand;
    logic               sel_any, deq, deq_tail;
    logic               credit_vld_q;
    logic [VC_BITS-1:0] credit_vc_q;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        assign hit[v]   = fin.valid && (fin.vc == VC_BITS'(v));
        assign rd_en[v] = deq && (sel == VC_BITS'(v));
        assign room[v]  = (count[v] < CNT_W'(BUF_DEPTH));
        // A dequeue in the same cycle frees the slot this write needs.
        assign wr_en[v] = hit[v] && (room[v] || rd_en[v]);
        assign ovf[v]   = hit[v] && full[v] && !rd_en[v];

        flit_vc_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (wr_en[v]),
            .wr_data ({fin.tail, fin.data}),
            .rd_en   (rd_en[v]),
            .rd_data (head[v]),
            .count   (count[v]),
            .full    (full[v]),
            .empty   (empty[v])
        );
    end

    // Selector state: IDLE/LOCKED, locked VC and round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= SEL_IDLE;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Lock on a non-tail dequeue, unlock on a tail; pointer moves past the served VC.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        if (deq) begin
            rr_ptr_d = (int'(sel) == NUM_VCS - 1) ? '0 : sel + 1'b1;
            if (deq_tail) begin
                state_d = SEL_IDLE;
            end else begin
                state_d   = SEL_LOCKED;
                lock_vc_d = sel;
            end
        end
    end

    // Pick the presented VC: the locked one only, or round-robin from rr_ptr.
    always_comb begin
        sel     = '0;
        sel_any = 1'b0;
        cand    = '0;
        if (state_q == SEL_LOCKED) begin
            sel     = lock_vc_q;
            sel_any = !empty[lock_vc_q];
        end else begin
            // Scan lowest priority first so the highest-priority hit wins.
            for (int i = NUM_VCS - 1; i >= 0; i--) begin
                cand = VC_BITS'((int'(rr_ptr_q) + i) % NUM_VCS);
                if (!empty[cand]) begin
                    sel     = cand;
                    sel_any = 1'b1;
                end
            end
        end
    end

    assign deq      = sel_any && bus.out_ready;
    assign deq_tail = deq && head[sel][ENTRY_W-1];

    assign bus.out_valid = sel_any;
    assign bus.out_data  = sel_any ? head[sel][FLIT_DATA_WIDTH-1:0] : '0;
    assign bus.out_tail  = sel_any && head[sel][ENTRY_W-1];
    assign bus.out_vc    = sel_any ? sel : '0;

    // One registered credit per dequeue, returned the edge after it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credit_vld_q <= 1'b0;
            credit_vc_q  <= '0;
        end else begin
            credit_vld_q <= deq;
            credit_vc_q  <= deq ? sel : '0;
        end
    end

    assign bus.credit_out    = {credit_vld_q, credit_vc_q};
    assign bus.credit_out_en = credit_vld_q;

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) error_overflow <= 1'b0;
        else        error_overflow <= error_overflow | (|ovf);
    end

`ifdef FLIT_RECV_STATS_EN
    // Dequeued flit and packet counters, free-running modulo 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_flits <= '0;
            stat_pkts  <= '0;
        end else begin
            stat_flits <= stat_flits + 32'(deq);
            stat_pkts  <= stat_pkts + 32'(deq_tail);
        end
    end
`endif

endmodule

// File: tb/tb_flit_recv_endpoint.sv
// Directed bench for flit_recv_endpoint with a scoreboard of expected
// user-side flits and a per-cycle credit check derived from it.
module tb_flit_recv_endpoint;
    import connect_flit_pkg::*;

    logic clock;
    logic reset;
    logic error_overflow;
`ifdef FLIT_RECV_STATS_EN
    logic [31:0] stat_flits;
    logic [31:0] stat_pkts;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        vc;
        logic        tail;
        logic [39:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] credit_exp;

    flit_recv_endpoint_if #(.NUM_VCS(2), .FLIT_DATA_WIDTH(40), .DEST_BITS(2)) bus ();

    flit_recv_endpoint #(
        .NUM_VCS(2), .FLIT_DATA_WIDTH(40), .DEST_BITS(2), .BUF_DEPTH(4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .error_overflow (error_overflow)
`ifdef FLIT_RECV_STATS_EN
        ,
        .stat_flits     (stat_flits),
        .stat_pkts      (stat_pkts)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted flit and checks the
    // credit that the previous cycle's dequeue must produce.
    always @(negedge clock) begin
        logic [1:0] nxt;
        exp_t       e;
        nxt = 2'b00;
        if (!reset) credit_exp = 2'b00;
        chk("credit_out", bus.credit_out, credit_exp);
        chk("credit_out_en", bus.credit_out_en, credit_exp[1]);
        if (!reset) begin
            sb.delete();
        end else if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_flit", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_tail", bus.out_tail, e.tail);
                chk("out_vc", bus.out_vc, e.vc);
                nxt = {1'b1, e.vc};
            end
        end else if (!bus.out_valid) begin
            chk("idle_zero", {bus.out_data, bus.out_tail, bus.out_vc}, 0);
        end
        credit_exp = nxt;
    end

    task automatic drive(input logic vc, input logic tail, input logic [39:0] data, input bit push);
        flit_t f;
        f.valid = 1'b1;
        f.tail  = tail;
        f.dest  = data[1:0];
        f.vc    = vc;
        f.data  = data;
        bus.flit_in = f;
        if (push) sb.push_back('{vc: vc, tail: tail, data: data});
    endtask

    task automatic send(input logic vc, input logic tail, input logic [39:0] data, input bit push);
        drive(vc, tail, data, push);
        @(posedge clock); #1;
        bus.flit_in = '0;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_err", error_overflow, 0);
        chk("rst_credit", bus.credit_out, 0);
        @(posedge clock); #1 reset = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk(tag, sb.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        credit_exp    = 2'b00;
        reset         = 1'b0;
        bus.flit_in   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_err", error_overflow, 0);
        @(posedge clock); #1 reset = 1'b1;

        // Two-flit packet on vc0, one-cycle latency and back-to-back credits.
        bus.out_ready = 1'b1;
        send(1'b0, 1'b0, 40'ha, 1);
        drive(1'b0, 1'b1, 40'hb, 1);
        @(negedge clock);
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_data_a", bus.out_data, 40'ha);
        @(posedge clock); #1 bus.flit_in = '0;
        @(negedge clock);
        chk("lat_data_b", bus.out_data, 40'hb);
        chk("lat_tail_b", bus.out_tail, 1);
        wait_drain("drain_basic");
`ifdef FLIT_RECV_STATS_EN
        chk("stat_flits", stat_flits, 2);
        chk("stat_pkts", stat_pkts, 1);
`endif

        // Overflow on vc1: four buffered, fifth dropped, nothing credited.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(1'b1, (i == 3), 40'h10 + 40'(i), (i < 4));
        @(negedge clock);
        chk("ovf_flag", error_overflow, 1);
        chk("ovf_hold_valid", bus.out_valid, 1);
        chk("ovf_hold_data0", bus.out_data, 40'h10);
        @(negedge clock);
        chk("ovf_hold_data1", bus.out_data, 40'h10);
        @(posedge clock); #1 bus.out_ready = 1'b1;
        wait_drain("drain_ovf");
        chk("ovf_sticky", error_overflow, 1);

        // Packet lock: vc1 single flit must wait for the vc0 tail.
        pulse_reset();
        bus.out_ready = 1'b1;
        send(1'b0, 1'b0, 40'ha1, 1);
        send(1'b1, 1'b1, 40'hb1, 0);
        @(negedge clock);
        chk("lock_hold", bus.out_valid, 0);
        @(posedge clock); #1;
        send(1'b0, 1'b1, 40'ha2, 1);
        sb.push_back('{vc: 1'b1, tail: 1'b1, data: 40'hb1});
        wait_drain("drain_lock");

        // Round-robin between single-flit packets on both VCs.
        pulse_reset();
        bus.out_ready = 1'b0;
        send(1'b0, 1'b1, 40'hc0, 1);
        send(1'b1, 1'b1, 40'hd0, 1);
        send(1'b0, 1'b1, 40'hc1, 1);
        send(1'b1, 1'b1, 40'hd1, 1);
        bus.out_ready = 1'b1;
        wait_drain("drain_rr");

        // Reset in the middle of a locked packet with buffered and dropped flits.
        send(1'b0, 1'b0, 40'he0, 1);
        wait_drain("drain_pre_rst");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(1'b0, 1'b0, 40'he1 + 40'(i), 0);
        send(1'b1, 1'b1, 40'hf0, 0);
        @(negedge clock);
        chk("mid_err", error_overflow, 1);
        chk("mid_valid", bus.out_valid, 1);
        pulse_reset();
        bus.out_ready = 1'b1;
        send(1'b1, 1'b0, 40'h70, 1);
        @(negedge clock);
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_vc", bus.out_vc, 1);
        @(posedge clock); #1;
        send(1'b1, 1'b1, 40'h71, 1);
        wait_drain("drain_post_rst");
        chk("final_err", error_overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flit_recv_endpoint.md
FLIT_RECV_ENDPOINT -- requirements
Module: flit_recv_endpoint

Interface
REQ-001 Parameter NUM_VCS, default 2: number of virtual channels; VC_BITS = clog2(NUM_VCS), min 1.
REQ-002 Parameter FLIT_DATA_WIDTH, default 40: flit payload width.
REQ-003 Parameter DEST_BITS, default 2: destination field width.
REQ-004 Parameter BUF_DEPTH, default 4: per-VC buffer entries; power of two, >=2; equals initial credits the network holds per VC.
REQ-005 Derived: FLIT_W = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS; CREDIT_W = 1 + VC_BITS.
REQ-006 clock  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 flit_in  input  FLIT_W  from network receive port; layout {valid, tail, dest, vc, data}, MSB first.
REQ-009 credit_out  output  CREDIT_W  {valid, vc} credit to network receive-port credit input.
REQ-010 credit_out_en  output  1  credit enable; equals credit_out valid bit.
REQ-011 out_valid  output  1  user-side flit available.
REQ-012 out_ready  input  1  user-side accept.
REQ-013 out_data  output  FLIT_DATA_WIDTH  payload of presented flit.
REQ-014 out_tail  output  1  presented flit is packet tail.
REQ-015 out_vc  output  VC_BITS  VC of presented flit.
REQ-016 error_overflow  output  1  sticky: flit arrived for full VC buffer.

Function
REQ-017 Flit with valid=1 SHALL be written into FIFO[vc] at the same edge; data, tail, vc stored, dest discarded.
REQ-018 Write SHALL succeed if FIFO[vc] count < BUF_DEPTH or a dequeue from that VC occurs the same cycle; otherwise flit dropped and error_overflow set.
REQ-019 Dequeue occurs when out_valid & out_ready; at most one per cycle.
REQ-020 Minimum latency: flit written at edge N SHALL be presented (out_valid=1) in cycle after edge N.
REQ-021 Outputs out_data/out_tail/out_vc SHALL be driven from selected FIFO head combinationally; stable while out_valid & !out_ready.
REQ-022 Selector FSM: IDLE -- select by round-robin among non-empty VCs, starting after last-served VC; LOCKED(v) -- serve VC v only.
REQ-023 IDLE -> LOCKED(v) on dequeue of non-tail flit from v; LOCKED(v) -> IDLE on dequeue of tail from v; single-flit (tail) packet stays IDLE, pointer advances.
REQ-024 In LOCKED(v) with FIFO[v] empty, out_valid SHALL be 0 even if other VCs non-empty.
REQ-025 Each dequeue from VC v SHALL emit exactly one registered credit {1, v} at the following edge, held one cycle; credit_out = 0 otherwise.
REQ-026 Per-VC occupancy counters SHALL be BUF_DEPTH+1 states wide; pointers wrap modulo BUF_DEPTH.
REQ-027 Dropped flits SHALL emit no credit and not alter FSM.
REQ-028 error_overflow clears only on reset.

Reset
REQ-029 On reset low: all FIFOs empty, FSM IDLE, round-robin pointer VC 0, credit_out=0, credit_out_en=0, out_valid=0, error_overflow=0, regardless of in-flight packet.
REQ-030 out_data/out_tail/out_vc SHALL read 0 while out_valid=0.

Configuration
REQ-031 Macro FLIT_RECV_STATS_EN defined: add outputs stat_flits and stat_pkts (32 bits each), counting dequeued flits and dequeued tails, wrapping at 2^32, reset to 0.
REQ-032 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Package connect_flit_pkg SHALL hold flit/credit width constants, field offset constants, and flit/credit typedefs, shared with send-side blocks.
REQ-034 One sub-module flit_vc_fifo (depth BUF_DEPTH, count, full/empty) instantiated NUM_VCS times.

Verification
REQ-035 flit_in valid vc0 data 0xa tail0 at edge 4, data 0xb tail1 at edge 5, out_ready=1 -> out 0xa cycle 5, 0xb tail cycle 6; credits {1,0} after edges 5 and 6.
REQ-036 out_ready=0, five vc1 flits -> first four buffered, fifth dropped, error_overflow=1, no credits; then out_ready=1 -> four flits in order, four credits {1,1} on consecutive cycles.
REQ-037 vc0 head, then vc1 single-flit, then vc0 tail, out_ready=1 -> vc0 head, vc0 tail, then vc1; vc1 never interleaved mid-packet.
REQ-038 Continuous single-flit packets on both VCs, out_ready=1 -> out_vc alternates 0,1,0,1.
REQ-039 Reset asserted mid-packet with flits buffered -> next cycle out_valid=0, credit_out=0, error_overflow=0; new packet vc1 after release served immediately.
REQ-040 With FLIT_RECV_STATS_EN, scenario REQ-035 -> stat_flits=2, stat_pkts=1.
